ln_stats_core: RTL and testbench
================================

Name: ln_stats_core

Overview:
- Responder side of the LayerNorm valid/ready interface. It accepts one 64-lane x 16-bit input vector per transaction on the in_valid/in_ready/a_in port.
- It computes the vector mean and variance serially, LANES lanes per cycle, then presents the result on out_valid/out_ready.
- It sits directly under the LN stimulus/control FSM. It is the first stage of the LayerNorm datapath and feeds the normalize stage.

Parameters:
- N, 64, lanes per input vector (power of two)
- W, 16, bits per lane, signed two's complement
- LANES, 4, lanes accumulated per cycle (power of two, divides N)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  core can accept a vector
- a_in  in  N*W  input vector; lane i = a_in[W*i+W-1 : W*i]
- out_valid  out  1  mean_out/var_out valid
- out_ready  in  1  consumer accepts result
- mean_out  out  W  signed mean
- var_out  out  2*W  unsigned variance

Behaviour:
- States: IDLE, ACCUM, FINAL, DONE.
- in_ready = (state==IDLE), decoded from state; out_valid = (state==DONE).
- Reset (async, rst_n low):
  - state=IDLE, so in_ready=1 and out_valid=0
  - mean_out=0, var_out=0
  - sum, sumsq, chunk counter and captured vector all cleared
- IDLE:
  - On an edge with in_valid=1, capture a_in into an N*W register, clear sum/sumsq/counter, go to ACCUM.
  - a_in may change after the accept edge.
  - in_valid is ignored in every state other than IDLE.
- ACCUM:
  - Each edge adds chunk k (lanes LANES*k .. LANES*k+LANES-1) to the accumulators:
    - sum += sign-extended x
    - sumsq += x*x
  - k runs 0..N/LANES-1; after chunk N/LANES-1, go to FINAL.
  - Default config: 16 ACCUM cycles.
- FINAL (1 cycle), computes:
  - mean = sum >>> log2(N), arithmetic shift, floor
  - ex2 = sumsq >> log2(N)
  - var = ex2 - mean*mean, clamped to 0 if negative
  - Registers mean_out/var_out, then goes to DONE.
- DONE:
  - out_valid=1; mean_out/var_out held stable.
  - On an edge with out_ready=1, go to IDLE; in_ready=1 from the next cycle.
  - out_ready may be held high continuously; the handshake then completes in the first DONE cycle.
- Latency: accept edge E0; out_valid first high after edge E(N/LANES+1). Default: 17 cycles.
- Throughput: one vector per N/LANES+3 cycles minimum (default 19).
- Widths (default):
  - sum: W+log2(N) = 22 bits signed
  - sumsq: 2W+log2(N) = 38 bits unsigned (max 2^36)
  - ex2 and mean^2 fit in 2W bits; var_out is 2W bits.
- mean_out and var_out retain their last value after the DONE handshake until the next FINAL.
- Reset mid-transaction (any state): immediate return to IDLE with reset values; the partial result is discarded.
- No overflow or saturation is possible for any input within the declared widths.

Test Plan:
- Reset, then all 64 lanes = 16'h0208, out_ready=1 -> out_valid exactly 17 cycles after the accept edge; mean_out=16'h0208, var_out=0; in_ready back to 1 the cycle after the handshake.
- Even lanes 16'h0100, odd lanes 16'hFF00 -> mean_out=16'h0000, var_out=32'h0001_0000.
- All lanes 16'hFFFF -> mean_out=16'hFFFF (-1), var_out=0. All lanes 0 -> mean_out=0, var_out=0.
- Lane i = i (0..63) -> sum=2016, sumsq=85344; mean_out=31, var_out=1333-961=372.
- out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0, in_valid pulses ignored. Then raise out_ready -> IDLE.
- Back-to-back: drive the four distinct vectors in sequence as the LN control FSM does (in_valid pulse one cycle after in_ready seen, out_ready tied 1) -> four correct results in order. Then assert rst_n low mid-ACCUM of a fifth vector -> in_ready=1, out_valid=0, mean_out=0, var_out=0 immediately; the next vector computes correctly.

Source files
------------

// File: rtl/ln_stats_core.sv
// LayerNorm statistics stage: captures one N-lane vector, accumulates sum and
// sum of squares LANES lanes per cycle, then produces floor mean and variance.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// ACCUM | adding one LANES-wide chunk per cycle into sum/sumsq
// FINAL | one cycle: derive mean/variance from accumulators, register them
// DONE  | result presented on out_valid until out_ready
module ln_stats_core #(
   parameter int N     = 64,
   parameter int W     = 16,
   parameter int LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*W-1:0]       a_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [W-1:0]  mean_out,
   output logic [2*W-1:0]       var_out
);

   localparam int LOG2N  = $clog2(N);
   localparam int CHUNKS = N / LANES;
   localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int SW     = W + LOG2N;
   localparam int QW     = 2*W + LOG2N;

   typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

   state_t                 state_q, state_d;
   logic [N*W-1:0]         vec_q;
   logic [KW-1:0]          k_q;
   logic signed [SW-1:0]   sum_q;
   logic [QW-1:0]          sumsq_q;

   logic signed [SW-1:0]   chunk_sum;
   logic [QW-1:0]          chunk_sq;
   logic signed [W-1:0]    lane;
   logic signed [2*W-1:0]  lane_sq;

   logic signed [W-1:0]    mean_d;
   logic signed [2*W-1:0]  msq_s;
   logic [2*W-1:0]         msq;
   logic [2*W-1:0]         ex2;
   logic [2*W-1:0]         var_d;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = ACCUM;
         ACCUM:   if (k_q == KW'(CHUNKS-1)) state_d = FINAL;
         FINAL:   state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Current chunk k_q: lanes LANES*k .. LANES*k+LANES-1 of the captured vector.
   always_comb begin
      chunk_sum = '0;
      chunk_sq  = '0;
      lane      = '0;
      lane_sq   = '0;
      for (int j = 0; j < LANES; j++) begin
         lane      = $signed(vec_q[(int'(k_q) * LANES + j) * W +: W]);
         lane_sq   = (2*W)'(lane) * (2*W)'(lane);
         chunk_sum = chunk_sum + SW'(lane);
         chunk_sq  = chunk_sq + QW'($unsigned(lane_sq));
      end
   end

   // Dropping the low LOG2N bits of the signed sum is the floor division by N.
   assign mean_d = $signed(sum_q[SW-1:LOG2N]);
   assign ex2    = sumsq_q[QW-1:LOG2N];
   assign msq_s  = (2*W)'(mean_d) * (2*W)'(mean_d);
   assign msq    = $unsigned(msq_s);
   // Flooring both terms can make ex2 smaller than mean^2; clamp at zero.
   assign var_d  = (ex2 >= msq) ? (ex2 - msq) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q    <= '0;
         k_q      <= '0;
         sum_q    <= '0;
         sumsq_q  <= '0;
         mean_out <= '0;
         var_out  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  vec_q   <= a_in;
                  k_q     <= '0;
                  sum_q   <= '0;
                  sumsq_q <= '0;
               end
            end
            ACCUM: begin
               sum_q   <= sum_q + chunk_sum;
               sumsq_q <= sumsq_q + chunk_sq;
               k_q     <= k_q + KW'(1);
            end
            FINAL: begin
               mean_out <= mean_d;
               var_out  <= var_d;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ln_stats_core.sv
// Directed bench for ln_stats_core: latency, mean/variance of hand-computed
// vectors, DONE back-pressure, back-to-back vectors and mid-ACCUM reset.
module tb_ln_stats_core;

   localparam int N = 64;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] a_in;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   mean_out;
   logic [2*W-1:0] var_out;

   int n_chk = 0;
   int n_err = 0;

   ln_stats_core #(.N(N), .W(W), .LANES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mean_out  (mean_out),
      .var_out   (var_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N*W-1:0] vec_fill(input logic [W-1:0] even, input logic [W-1:0] odd);
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[W*i +: W] = (i % 2 == 0) ? even : odd;
      return v;
   endfunction

   function automatic logic [N*W-1:0] vec_ramp();
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[W*i +: W] = W'(i);
      return v;
   endfunction

   // Accept edge is E0; count edges until out_valid is first seen high.
   task automatic wait_result(input string tag, output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, 64'(cyc), 64'd17);
   endtask

   task automatic send(input logic [N*W-1:0] v);
      @(negedge clk);
      in_valid = 1'b1;
      a_in     = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_in     = {N*W/32{$urandom}};
   endtask

   task automatic run_vec(input string tag, input logic [N*W-1:0] v,
                          input logic [W-1:0] em, input logic [2*W-1:0] ev);
      int cyc;
      send(v);
      check({tag, "_busy"}, 64'(in_ready), 64'd0);
      wait_result(tag, cyc);
      check({tag, "_mean"}, 64'(mean_out), 64'(em));
      check({tag, "_var"}, 64'(var_out), 64'(ev));
      @(posedge clk); #1;
      check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
      check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int cyc;
      logic [N*W-1:0] v;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a_in      = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_mean", 64'(mean_out), 64'd0);
      check("rst_var", 64'(var_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_vec("const208", vec_fill(16'h0208, 16'h0208), 16'h0208, 32'h0);
      run_vec("alt100",   vec_fill(16'h0100, 16'hFF00), 16'h0000, 32'h0001_0000);
      run_vec("allneg1",  vec_fill(16'hFFFF, 16'hFFFF), 16'hFFFF, 32'h0);
      run_vec("zeros",    vec_fill(16'h0000, 16'h0000), 16'h0000, 32'h0);
      run_vec("ramp",     vec_ramp(), 16'd31, 32'd372);

      // floor(-1/64) = -1 gives mean^2 = 1 > ex2 = 0: variance must clamp.
      v = '0;
      v[W-1:0] = 16'hFFFF;
      run_vec("clamp", v, 16'hFFFF, 32'h0);
      run_vec("minval", vec_fill(16'h8000, 16'h8000), 16'h8000, 32'h0);

      // Back-pressure in DONE with ignored in_valid pulses.
      out_ready = 1'b0;
      send(vec_ramp());
      wait_result("stall", cyc);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a_in     = vec_fill(16'h7000, 16'h1234);
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_mean", 64'(mean_out), 64'd31);
         check("stall_var", 64'(var_out), 64'd372);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_release_ready", 64'(in_ready), 64'd1);
      check("stall_release_valid", 64'(out_valid), 64'd0);
      check("stall_retain_mean", 64'(mean_out), 64'd31);
      check("stall_retain_var", 64'(var_out), 64'd372);
      @(posedge clk); #1;
      check("stall_no_accept", 64'(in_ready), 64'd1);

      // Back-to-back as driven by the LN control FSM.
      run_vec("b2b0", vec_fill(16'h0208, 16'h0208), 16'h0208, 32'h0);
      run_vec("b2b1", vec_fill(16'h0100, 16'hFF00), 16'h0000, 32'h0001_0000);
      run_vec("b2b2", vec_fill(16'hFFFF, 16'hFFFF), 16'hFFFF, 32'h0);
      run_vec("b2b3", vec_ramp(), 16'd31, 32'd372);

      // Reset in the middle of ACCUM discards everything immediately.
      send(vec_fill(16'h0208, 16'h0208));
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_mean", 64'(mean_out), 64'd0);
      check("midrst_var", 64'(var_out), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec("postrst", vec_fill(16'h0100, 16'hFF00), 16'h0000, 32'h0001_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
